// File: rtl/cache_refill_if.sv
// Cache-side and memory-side signals of the single-line refill controller.
// The controller connects through master; the cache/memory environment through slave.
interface cache_refill_if;
    logic        miss;
    logic [31:0] miss_addr;
    logic        stall;
    logic        refill;
    logic [31:0] refill_addr;
    logic [31:0] refill_data;
    logic [3:0]  refill_wen;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rready;
    logic        bus_err;

    modport master (
        input  miss, miss_addr, mem_arready, mem_rvalid, mem_rdata, mem_rresp,
        output stall, refill, refill_addr, refill_data, refill_wen,
               mem_arvalid, mem_araddr, mem_rready, bus_err
    );

    modport slave (
        output miss, miss_addr, mem_arready, mem_rvalid, mem_rdata, mem_rresp,
        input  stall, refill, refill_addr, refill_data, refill_wen,
               mem_arvalid, mem_araddr, mem_rready, bus_err
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Single-outstanding cache line refill controller: one word read per miss,
// one-cycle refill strobe, saturating miss and bus-error counters.
module cache_refill_ctrl #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_refill_if.master       bus,
    output logic [31:0]          miss_cnt,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] RESP   = 3'd2;
    localparam logic [2:0] REFILL = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic                 err_q, err_d;
    logic [31:0]          miss_cnt_q, miss_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    function automatic logic [31:0] sat_inc_miss(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = err_q;
        miss_cnt_d = miss_cnt_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.miss) begin
                    addr_d     = bus.miss_addr & 32'hFFFF_FFFC;
                    miss_cnt_d = sat_inc_miss(miss_cnt_q);
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (bus.mem_arready) state_d = RESP;
            end
            RESP: begin
                if (bus.mem_rvalid) begin
                    if (bus.mem_rresp == 2'b00) begin
                        data_d  = bus.mem_rdata;
                        state_d = REFILL;
                    end else begin
                        // Failed read skips the refill; the flag marks the DONE cycle.
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc_err(err_cnt_q);
                        state_d   = DONE;
                    end
                end
            end
            REFILL: state_d = DONE;
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            miss_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
            miss_cnt_q <= miss_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // DONE drops stall so the cache re-lookup sees the freshly written line.
    assign bus.stall       = ((state_q != IDLE) && (state_q != DONE)) ||
                             ((state_q == IDLE) && bus.miss);
    assign bus.mem_arvalid = (state_q == REQ);
    assign bus.mem_araddr  = (state_q == REQ) ? addr_q : '0;
    assign bus.mem_rready  = (state_q == RESP);
    assign bus.refill      = (state_q == REFILL);
    assign bus.refill_addr = (state_q == REFILL) ? addr_q : '0;
    assign bus.refill_data = (state_q == REFILL) ? data_q : '0;
    assign bus.refill_wen  = (state_q == REFILL) ? 4'hF : 4'h0;
    assign bus.bus_err     = (state_q == DONE) && err_q;
    assign miss_cnt        = miss_cnt_q;
    assign err_cnt         = err_cnt_q;
endmodule
